key_conditioner: RTL and testbench

- Parametrised N-channel push-button conditioner for the lab top levels.
- Replaces the fixed single-key debounce plus autorepeat pair.
- Per key it provides synchronisation, tick-based debounce, a one-clock press pulse and an optional autorepeat pulse train.
- It is the clock-enable / step source for datapath single-stepping and for UI keys.

---
 rtl/key_conditioner.sv | 163 ++++++++++++++++
 tb/tb_key_conditioner.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// key_conditioner: N-channel push-button synchroniser, tick-based debouncer and autorepeat pulse source.
// Defining KEY_RELEASE_PULSE_EN adds the keyrel output (one-cycle pulse on each debounced release).
module key_conditioner #(
    parameter int NKEYS     = 4,
    parameter int CLK_DIV   = 1000000,
    parameter int DEB_TICKS = 3,
    parameter int RPT_DELAY = 50,
    parameter int RPT_RATE  = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NKEYS-1:0] keyin,
    input  logic [NKEYS-1:0] rpten,
    output logic             tick,
`ifdef KEY_RELEASE_PULSE_EN
    output logic [NKEYS-1:0] keyrel,
`endif
    output logic [NKEYS-1:0] keylevel,
    output logic [NKEYS-1:0] keypulse
);
    localparam int TW   = $clog2(CLK_DIV);
    localparam int DW   = $clog2(DEB_TICKS + 1);
    localparam int RMAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DEB_LIMIT = DW'(DEB_TICKS);
    localparam logic [RW-1:0] RPT_FIRST = RW'(RPT_DELAY);
    localparam logic [RW-1:0] RPT_NEXT  = RW'(RPT_RATE);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT, HELD} state_t;

    logic [NKEYS-1:0]         sync1_q, sync2_q;
    logic [TW-1:0]            tickCnt_q;
    logic [NKEYS-1:0]         level_q, level_d;
    logic [NKEYS-1:0][DW-1:0] debCnt_q, debCnt_d;

    assign tick     = (tickCnt_q == TICK_LAST);
    assign keylevel = level_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            tickCnt_q <= '0;
        end else begin
            sync1_q   <= keyin;
            sync2_q   <= sync1_q;
            tickCnt_q <= tick ? '0 : tickCnt_q + TW'(1);
        end
    end

    // The repeat FSMs look at level_d so the press pulse lands on the same edge the level rises.
    always_comb begin
        level_d  = level_q;
        debCnt_d = debCnt_q;
        for (int k = 0; k < NKEYS; k++) begin
            if (tick) begin
                if (sync2_q[k] == level_q[k]) begin
                    debCnt_d[k] = '0;
                end else if (debCnt_q[k] + DW'(1) == DEB_LIMIT) begin
                    level_d[k]  = ~level_q[k];
                    debCnt_d[k] = '0;
                end else begin
                    debCnt_d[k] = debCnt_q[k] + DW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            level_q  <= '0;
            debCnt_q <= '0;
        end else begin
            level_q  <= level_d;
            debCnt_q <= debCnt_d;
        end
    end

    for (genvar g = 0; g < NKEYS; g++) begin : g_key
        state_t        state_q;
        logic [RW-1:0] rptCnt_q;
        logic          pulse_q;
        logic          rise, fall;

        assign rise = level_d[g] & ~level_q[g];
        assign fall = level_q[g] & ~level_d[g];

        // A release always wins over a repeat expiry on the same tick.
        always_ff @(posedge clock) begin
            if (reset) begin
                state_q  <= IDLE;
                rptCnt_q <= '0;
                pulse_q  <= 1'b0;
            end else begin
                pulse_q <= 1'b0;
                if (fall) begin
                    state_q  <= IDLE;
                    rptCnt_q <= '0;
                end else begin
                    case (state_q)
                        IDLE: begin
                            if (rise) begin
                                pulse_q  <= 1'b1;
                                rptCnt_q <= '0;
                                state_q  <= rpten[g] ? DELAY : HELD;
                            end
                        end
                        DELAY: begin
                            if (!rpten[g]) begin
                                state_q <= HELD;
                            end else if (tick) begin
                                if (rptCnt_q + RW'(1) == RPT_FIRST) begin
                                    pulse_q  <= 1'b1;
                                    rptCnt_q <= '0;
                                    state_q  <= REPEAT;
                                end else begin
                                    rptCnt_q <= rptCnt_q + RW'(1);
                                end
                            end
                        end
                        REPEAT: begin
                            if (!rpten[g]) begin
                                state_q <= HELD;
                            end else if (tick) begin
                                if (rptCnt_q + RW'(1) == RPT_NEXT) begin
                                    pulse_q  <= 1'b1;
                                    rptCnt_q <= '0;
                                end else begin
                                    rptCnt_q <= rptCnt_q + RW'(1);
                                end
                            end
                        end
                        HELD: begin
                            if (rpten[g]) begin
                                state_q  <= DELAY;
                                rptCnt_q <= '0;
                            end
                        end
                        default: state_q <= IDLE;
                    endcase
                end
            end
        end

        assign keypulse[g] = pulse_q;

`ifdef KEY_RELEASE_PULSE_EN
        logic rel_q;

        always_ff @(posedge clock) begin
            if (reset) begin
                rel_q <= 1'b0;
            end else begin
                rel_q <= fall;
            end
        end

        assign keyrel[g] = rel_q;
`endif
    end
endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: directed steps push expected output events into a
// scoreboard keyed on absolute cycle number; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_key_conditioner;
    localparam int NK         = 4;
    localparam int KIND_RISE  = 1;
    localparam int KIND_FALL  = 2;
    localparam int KIND_PULSE = 3;
    localparam int KIND_REL   = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [NK-1:0] keyin = '0;
    logic [NK-1:0] rpten = '0;
    logic          tick;
    logic [NK-1:0] keylevel;
    logic [NK-1:0] keypulse;
`ifdef KEY_RELEASE_PULSE_EN
    logic [NK-1:0] keyrel;
`endif

    longint        cycleCount = 0;
    longint        sinceReset = 0;
    longint        sb[$];
    logic [NK-1:0] prevLevel = '0;
    bit            monOn = 1'b0;
    int            checks = 0;
    int            failures = 0;

    key_conditioner #(
        .NKEYS(NK), .CLK_DIV(4), .DEB_TICKS(3), .RPT_DELAY(5), .RPT_RATE(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .keyin(keyin),
        .rpten(rpten),
        .tick(tick),
`ifdef KEY_RELEASE_PULSE_EN
        .keyrel(keyrel),
`endif
        .keylevel(keylevel),
        .keypulse(keypulse)
    );

    always #5 clock = ~clock;

    // sinceReset mirrors the shared tick counter: tick is due whenever it is 3 mod 4.
    always @(posedge clock) begin
        cycleCount <= cycleCount + 1;
        sinceReset <= reset ? 0 : sinceReset + 1;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Event code = cycle*100 + key*10 + kind, so a mismatch shows when, which key and what.
    task automatic expectEvent(input longint cyc, input int k, input int kind);
        sb.push_back(cyc * 100 + k * 10 + kind);
    endtask

    task automatic popEvent(input int k, input int kind);
        logic [63:0] obs;
        logic [63:0] exp;
        obs = cycleCount * 100 + k * 10 + kind;
        if (sb.size() == 0) exp = '1;
        else exp = sb.pop_front();
        checkOutput("event", obs, exp);
    endtask

    task automatic applyStimulus(input logic [NK-1:0] k, input logic [NK-1:0] r);
        keyin = k;
        rpten = r;
    endtask

    task automatic waitUntil(input longint c);
        while (cycleCount < c) @(negedge clock);
    endtask

    task automatic alignTick();
        while (sinceReset % 4 != 0) @(negedge clock);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_tick"}, tick, 1'b0);
        checkOutput({tag, "_keylevel"}, keylevel, '0);
        checkOutput({tag, "_keypulse"}, keypulse, '0);
`ifdef KEY_RELEASE_PULSE_EN
        checkOutput({tag, "_keyrel"}, keyrel, '0);
`endif
    endtask

    always @(negedge clock) begin
        if (monOn) begin
            checkOutput("tick", tick, (sinceReset % 4 == 3));
            for (int k = 0; k < NK; k++) begin
                if (keylevel[k] !== prevLevel[k]) popEvent(k, keylevel[k] ? KIND_RISE : KIND_FALL);
                if (keypulse[k] !== 1'b0) popEvent(k, KIND_PULSE);
`ifdef KEY_RELEASE_PULSE_EN
                if (keyrel[k] !== 1'b0) popEvent(k, KIND_REL);
`endif
            end
            prevLevel <= keylevel;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        longint t;
        $display("[TB] start");
        applyStimulus('0, '0);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        monOn = 1'b1;
        checkResetState("reset_hold");
        reset = 1'b0;
        waitUntil(cycleCount + 40);

        // Reset mid-count must bring the tick counter back to 0.
        while (sinceReset % 4 != 2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("tick_cleared_by_reset", tick, 1'b0);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("tick_after_reset", tick, 1'b1);

        // Key 0: two-tick glitch is rejected, then a three-tick press is accepted.
        alignTick();
        t = cycleCount;
        applyStimulus(4'b0001, 4'b0000);
        waitUntil(t + 8);
        applyStimulus(4'b0000, 4'b0000);
        waitUntil(t + 20);
        alignTick();
        t = cycleCount;
        expectEvent(t + 12, 0, KIND_RISE);
        expectEvent(t + 12, 0, KIND_PULSE);
        applyStimulus(4'b0001, 4'b0000);
        waitUntil(t + 12);
        applyStimulus(4'b0000, 4'b0000);
        expectEvent(t + 24, 0, KIND_FALL);
`ifdef KEY_RELEASE_PULSE_EN
        expectEvent(t + 24, 0, KIND_REL);
`endif
        waitUntil(t + 32);
        checkOutput("drained_key0", sb.size(), 0);

        // Key 1 autorepeat; the release lands on a repeat expiry tick, which must not pulse.
        alignTick();
        t = cycleCount;
        expectEvent(t + 12, 1, KIND_RISE);
        expectEvent(t + 12, 1, KIND_PULSE);
        expectEvent(t + 32, 1, KIND_PULSE);
        expectEvent(t + 40, 1, KIND_PULSE);
        expectEvent(t + 48, 1, KIND_PULSE);
        expectEvent(t + 56, 1, KIND_PULSE);
        applyStimulus(4'b0010, 4'b0010);
        waitUntil(t + 52);
        applyStimulus(4'b0000, 4'b0010);
        expectEvent(t + 64, 1, KIND_FALL);
`ifdef KEY_RELEASE_PULSE_EN
        expectEvent(t + 64, 1, KIND_REL);
`endif
        waitUntil(t + 76);
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("drained_key1", sb.size(), 0);

        // Key 2 held without repeat, then repeat enabled mid-hold away from a tick.
        alignTick();
        t = cycleCount;
        expectEvent(t + 12, 2, KIND_RISE);
        expectEvent(t + 12, 2, KIND_PULSE);
        applyStimulus(4'b0100, 4'b0000);
        waitUntil(t + 122);
        expectEvent(t + 140, 2, KIND_PULSE);
        expectEvent(t + 148, 2, KIND_PULSE);
        applyStimulus(4'b0100, 4'b0100);
        waitUntil(t + 140);
        applyStimulus(4'b0000, 4'b0100);
        expectEvent(t + 152, 2, KIND_FALL);
`ifdef KEY_RELEASE_PULSE_EN
        expectEvent(t + 152, 2, KIND_REL);
`endif
        waitUntil(t + 164);
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("drained_key2", sb.size(), 0);

        // All keys together, then reset mid-hold; held keys re-press after reset.
        alignTick();
        t = cycleCount;
        for (int k = 0; k < NK; k++) begin
            expectEvent(t + 12, k, KIND_RISE);
            expectEvent(t + 12, k, KIND_PULSE);
        end
        applyStimulus(4'b1111, 4'b0101);
        waitUntil(t + 20);
        reset = 1'b1;
        for (int k = 0; k < NK; k++) expectEvent(t + 21, k, KIND_FALL);
        @(negedge clock);
        checkResetState("reset_mid_hold");
        reset = 1'b0;
        t = cycleCount;
        for (int k = 0; k < NK; k++) begin
            expectEvent(t + 12, k, KIND_RISE);
            expectEvent(t + 12, k, KIND_PULSE);
        end
        waitUntil(t + 12);
        applyStimulus(4'b0000, 4'b0000);
        for (int k = 0; k < NK; k++) begin
            expectEvent(t + 24, k, KIND_FALL);
`ifdef KEY_RELEASE_PULSE_EN
            expectEvent(t + 24, k, KIND_REL);
`endif
        end
        waitUntil(t + 36);
        checkOutput("drained_multi", sb.size(), 0);

        // Key 3: glitch gives nothing (no release pulse either), real press/release gives one of each.
        alignTick();
        t = cycleCount;
        applyStimulus(4'b1000, 4'b0000);
        waitUntil(t + 8);
        applyStimulus(4'b0000, 4'b0000);
        waitUntil(t + 24);
        alignTick();
        t = cycleCount;
        expectEvent(t + 12, 3, KIND_RISE);
        expectEvent(t + 12, 3, KIND_PULSE);
        applyStimulus(4'b1000, 4'b0000);
        waitUntil(t + 12);
        applyStimulus(4'b0000, 4'b0000);
        expectEvent(t + 24, 3, KIND_FALL);
`ifdef KEY_RELEASE_PULSE_EN
        expectEvent(t + 24, 3, KIND_REL);
`endif
        waitUntil(t + 40);
        checkOutput("drained_final", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
